// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit with alignment checks, byte-lane steering,
// load extension and flush handling between execute and the data-memory port.
module lsu_ctrl #(
  parameter int XLEN = 32,
  parameter int NBYTES = XLEN / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_base_i,
  input  logic [XLEN-1:0]   req_offset_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [NBYTES-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              st_done_o,
  output logic              exc_valid_o,
  output logic [3:0]        exc_cause_o,
  output logic [XLEN-1:0]   exc_addr_o,
  output logic              busy_o
);
  localparam int OW = $clog2(NBYTES);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, EXC, DRAIN} state_t;
  state_t state, next;
  logic is_store, uns, accept, done, in_req;
  logic [1:0] size;
  logic [4:0] rd;
  logic [3:0] cause, cause_n;
  logic [2:0] amask;
  logic [7:0] mask8;
  logic [OW-1:0] off;
  logic [XLEN-1:0] sum, ea, rs2, ld_data, shifted, ext, lanes;
  assign sum = req_base_i + req_offset_i;
  assign accept = req_valid_i & (state == IDLE) & ~flush_i;
  assign amask = (3'd1 << req_size_i) - 3'd1;
  assign cause_n = (req_size_i == 2'b11 && XLEN == 32) ? 4'd2 :
                   ((sum[2:0] & amask) != 3'd0) ? (req_is_store_i ? 4'd6 : 4'd4) : 4'd0;
  assign off = ea[OW-1:0];
  assign mask8 = (size == 2'd0) ? 8'h01 : (size == 2'd1) ? 8'h03 : (size == 2'd2) ? 8'h0F : 8'hFF;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= next;
      if (accept) begin
        is_store <= req_is_store_i;
        size <= req_size_i;
        uns <= req_unsigned_i;
        ea <= sum;
        rs2 <= req_wdata_i;
        rd <= req_rd_i;
        cause <= cause_n;
      end
      if (state == WAIT && mem_rsp_valid_i) ld_data <= ext;
    end
  end
  // bits above the access width take the access sign bit unless zero-extending
  always_comb begin
    shifted = mem_rdata_i >> {off, 3'b000};
    ext = shifted;
    for (int i = 8; i < XLEN; i++)
      if (i >= (8 << size)) ext[i] = ~uns & shifted[(8 << size) - 1];
  end
  always_comb begin
    lanes = '0;
    for (int i = 0; i < NBYTES; i++) lanes[8*i +: 8] = rs2[8*(i & ((1 << size) - 1)) +: 8];
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = accept ? ((cause_n != 4'd0) ? EXC : REQ) : IDLE;
      REQ:   next = mem_req_ready_i ? (flush_i ? (is_store ? IDLE : DRAIN) : (is_store ? DONE : WAIT))
                                    : (flush_i ? IDLE : REQ);
      WAIT:  next = mem_rsp_valid_i ? (flush_i ? IDLE : DONE) : (flush_i ? DRAIN : WAIT);
      DRAIN: next = mem_rsp_valid_i ? IDLE : DRAIN;
      default: next = IDLE;
    endcase
  end
  assign in_req = (state == REQ);
  assign done = (state == DONE) & ~flush_i;
  assign req_ready_o = (state == IDLE);
  assign busy_o = (state != IDLE);
  assign mem_req_valid_o = in_req;
  assign mem_addr_o = in_req ? {ea[XLEN-1:OW], {OW{1'b0}}} : '0;
  assign mem_we_o = in_req & is_store;
  assign mem_be_o = in_req ? mask8[NBYTES-1:0] << off : '0;
  assign mem_wdata_o = in_req ? lanes : '0;
  assign st_done_o = done & is_store;
  assign wb_valid_o = done & ~is_store;
  assign wb_rd_o = wb_valid_o ? rd : '0;
  assign wb_data_o = wb_valid_o ? ld_data : '0;
  assign exc_valid_o = (state == EXC) & ~flush_i;
  assign exc_cause_o = exc_valid_o ? cause : '0;
  assign exc_addr_o = exc_valid_o ? ea : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: drives XLEN=32 and XLEN=64 instances against a transaction-level model.
module tb_lsu_ctrl;
  logic clk = 0, rst_n = 0, x64 = 0;
  logic req_valid = 0, is_store = 0, uns = 0, flush = 0, mreq_ready = 0, rsp_valid = 0;
  logic [1:0] size = 0;
  logic [4:0] rd = 0;
  logic [63:0] base = 0, offset = 0, wdata = 0, rdata = 0;
  int total = 0, bad = 0;
  logic r32, mv32, we32, wbv32, sd32, ev32, busy32;
  logic [3:0] be32, ec32;
  logic [4:0] wbrd32;
  logic [31:0] a32, wd32, wbd32, ea32;
  logic r64, mv64, we64, wbv64, sd64, ev64, busy64;
  logic [7:0] be64;
  logic [3:0] ec64;
  logic [4:0] wbrd64;
  logic [63:0] a64, wd64, wbd64, ea64;
  logic ready, mv, we, wbv, sd, ev, busy, others;
  logic [7:0] be;
  logic [3:0] ec;
  logic [4:0] wbrd;
  logic [63:0] addr, mwd, wbd, eaddr;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & ~x64), .req_ready_o(r32),
    .req_is_store_i(is_store), .req_size_i(size), .req_unsigned_i(uns),
    .req_base_i(base[31:0]), .req_offset_i(offset[31:0]), .req_wdata_i(wdata[31:0]), .req_rd_i(rd),
    .flush_i(flush), .mem_req_valid_o(mv32), .mem_req_ready_i(mreq_ready), .mem_addr_o(a32),
    .mem_we_o(we32), .mem_be_o(be32), .mem_wdata_o(wd32), .mem_rsp_valid_i(rsp_valid),
    .mem_rdata_i(rdata[31:0]), .wb_valid_o(wbv32), .wb_rd_o(wbrd32), .wb_data_o(wbd32),
    .st_done_o(sd32), .exc_valid_o(ev32), .exc_cause_o(ec32), .exc_addr_o(ea32), .busy_o(busy32)
  );
  lsu_ctrl #(.XLEN(64)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & x64), .req_ready_o(r64),
    .req_is_store_i(is_store), .req_size_i(size), .req_unsigned_i(uns),
    .req_base_i(base), .req_offset_i(offset), .req_wdata_i(wdata), .req_rd_i(rd),
    .flush_i(flush), .mem_req_valid_o(mv64), .mem_req_ready_i(mreq_ready), .mem_addr_o(a64),
    .mem_we_o(we64), .mem_be_o(be64), .mem_wdata_o(wd64), .mem_rsp_valid_i(rsp_valid),
    .mem_rdata_i(rdata), .wb_valid_o(wbv64), .wb_rd_o(wbrd64), .wb_data_o(wbd64),
    .st_done_o(sd64), .exc_valid_o(ev64), .exc_cause_o(ec64), .exc_addr_o(ea64), .busy_o(busy64)
  );

  assign ready = x64 ? r64 : r32;
  assign mv = x64 ? mv64 : mv32;
  assign we = x64 ? we64 : we32;
  assign wbv = x64 ? wbv64 : wbv32;
  assign sd = x64 ? sd64 : sd32;
  assign ev = x64 ? ev64 : ev32;
  assign busy = x64 ? busy64 : busy32;
  assign be = x64 ? be64 : {4'b0, be32};
  assign ec = x64 ? ec64 : ec32;
  assign wbrd = x64 ? wbrd64 : wbrd32;
  assign addr = x64 ? a64 : {32'b0, a32};
  assign mwd = x64 ? wd64 : {32'b0, wd32};
  assign wbd = x64 ? wbd64 : {32'b0, wbd32};
  assign eaddr = x64 ? ea64 : {32'b0, ea32};
  assign others = mv | we | wbv | sd | ev | busy | (|be) | (|ec) | (|wbrd) | (|addr) | (|mwd) | (|wbd) | (|eaddr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_be(int of, int nb);
    logic [63:0] v = 0;
    for (int k = 0; k < 8; k++) if (k >= of && k < of + nb) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_wd(logic [63:0] d, int nb, int xl);
    logic [63:0] v = 0;
    for (int k = 0; k < xl / 8; k++) v[8*k +: 8] = d[8*(k % nb) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] exp_ld(logic [63:0] d, int of, int nb, bit u, int xl);
    logic [63:0] v = 0;
    for (int j = 0; j < nb; j++) v[8*j +: 8] = d[8*(of + j) +: 8];
    if (!u && 8 * nb < xl && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    if (xl == 32) v[63:32] = 32'b0;
    return v;
  endfunction

  task automatic go_req(input bit st, input logic [1:0] sz, input bit u, input logic [63:0] b,
                        input logic [63:0] o, input logic [63:0] wd, input logic [4:0] r);
    chk("idle_ready", ready, 1);
    req_valid = 1; is_store = st; size = sz; uns = u; base = b; offset = o; wdata = wd; rd = r;
    @(negedge clk);
    req_valid = 0; is_store = $urandom; size = $urandom; uns = $urandom;
    base = {$urandom, $urandom}; offset = {$urandom, $urandom}; wdata = {$urandom, $urandom}; rd = $urandom;
  endtask

  task automatic run(input bit st, input logic [1:0] sz, input bit u, input logic [63:0] b,
                     input logic [63:0] o, input logic [63:0] wd, input logic [4:0] r,
                     input int rdel, input int ldel, input logic [63:0] rdat);
    logic [63:0] ea;
    int nb, of, xl, cause;
    xl = x64 ? 64 : 32;
    nb = 1 << sz;
    ea = b + o;
    if (!x64) ea[63:32] = 32'b0;
    of = x64 ? int'(ea[2:0]) : int'(ea[1:0]);
    cause = (sz == 2'd3 && !x64) ? 2 : (ea % nb != 0) ? (st ? 6 : 4) : 0;
    go_req(st, sz, u, b, o, wd, r);
    if (cause != 0) begin
      chk("exc_valid", ev, 1);
      chk("exc_cause", ec, cause);
      chk("exc_addr", eaddr, ea);
      chk("exc_noreq", mv, 0);
      @(negedge clk);
      chk("exc_pulse_end", ev, 0);
      chk("exc_ready", ready, 1);
      return;
    end
    for (int d = 0; d <= rdel; d++) begin
      chk("req_valid", mv, 1);
      chk("req_addr", addr, x64 ? (ea & ~64'd7) : (ea & ~64'd3));
      chk("req_we", we, st);
      chk("req_be", be, exp_be(of, nb));
      chk("req_wdata", mwd, exp_wd(wd, nb, xl));
      mreq_ready = (d == rdel);
      @(negedge clk);
    end
    mreq_ready = 0;
    if (st) begin
      chk("st_done", sd, 1);
      chk("st_no_wb", wbv, 0);
      @(negedge clk);
      chk("st_pulse_end", sd, 0);
      chk("st_ready", ready, 1);
      return;
    end
    for (int d = 1; d < ldel; d++) begin
      chk("wait_busy", {busy, ready, wbv, mv}, 4'b1000);
      @(negedge clk);
    end
    rsp_valid = 1; rdata = rdat;
    @(negedge clk);
    rsp_valid = 0; rdata = {$urandom, $urandom};
    chk("wb_valid", wbv, 1);
    chk("wb_rd", wbrd, r);
    chk("wb_data", wbd, exp_ld(x64 ? rdat : {32'b0, rdat[31:0]}, of, nb, u, xl));
    @(negedge clk);
    chk("wb_pulse_end", wbv, 0);
    chk("ld_ready", ready, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {ready, others}, 2'b10);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    x64 = 0; #1 chk_reset("rst32");
    x64 = 1; #1 chk_reset("rst64");
    x64 = 0;
    rst_n = 1;
    @(negedge clk);
    run(0, 2'd0, 0, 64'h1000, 64'd3, 64'h0, 5'd7, 0, 1, 64'h80FF_0000);
    run(0, 2'd0, 1, 64'h1000, 64'd3, 64'h0, 5'd8, 0, 1, 64'h80FF_0000);
    run(1, 2'd1, 0, 64'h2000, 64'd2, 64'hDEAD_BEEF, 5'd0, 2, 1, 64'h0);
    run(0, 2'd2, 0, 64'h1000, 64'd2, 64'h0, 5'd3, 0, 1, 64'h0);
    run(1, 2'd2, 0, 64'h1000, 64'd2, 64'h0, 5'd3, 0, 1, 64'h0);
    run(0, 2'd3, 0, 64'h1000, 64'd0, 64'h0, 5'd3, 0, 1, 64'h0);
    run(0, 2'd1, 0, 64'h3000, 64'd2, 64'h0, 5'd9, 1, 3, 64'h8123_4567);
    x64 = 1; #1;
    run(0, 2'd3, 0, 64'h0, 64'h8, 64'h0, 5'd5, 0, 1, 64'h8000_0000_0000_0001);
    run(0, 2'd2, 0, 64'h100, 64'h4, 64'h0, 5'd6, 0, 2, 64'h8765_4321_0000_0000);
    x64 = 0; #1;
    // flush during WAIT, response three cycles later is drained
    go_req(0, 2'd2, 0, 64'h4000, 64'd0, 64'h0, 5'd1);
    mreq_ready = 1;
    @(negedge clk);
    mreq_ready = 0; flush = 1;
    @(negedge clk);
    flush = 0;
    for (int d = 0; d < 2; d++) begin
      chk("drain_hold", {busy, ready, wbv}, 3'b100);
      @(negedge clk);
    end
    rsp_valid = 1; rdata = 64'h1234_5678;
    @(negedge clk);
    rsp_valid = 0;
    chk("drain_nowb", wbv, 0);
    chk("drain_ready", ready, 1);
    // flush in REQ before handshake
    go_req(1, 2'd2, 0, 64'h4000, 64'd4, 64'h55, 5'd1);
    chk("fr_req", mv, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fr_drop", {mv, ready}, 2'b01);
    // flush with handshake: store ends silently, load drains
    go_req(1, 2'd0, 0, 64'h4000, 64'd1, 64'h55, 5'd1);
    flush = 1; mreq_ready = 1;
    @(negedge clk);
    flush = 0; mreq_ready = 0;
    chk("fhs_st", {sd, ready}, 2'b01);
    go_req(0, 2'd0, 0, 64'h4000, 64'd1, 64'h0, 5'd1);
    flush = 1; mreq_ready = 1;
    @(negedge clk);
    flush = 0; mreq_ready = 0;
    chk("fhs_ld", {busy, ready}, 2'b10);
    rsp_valid = 1;
    @(negedge clk);
    rsp_valid = 0;
    chk("fhs_ld_end", {wbv, ready}, 2'b01);
    // flush in EXC and DONE suppresses the pulse
    go_req(0, 2'd2, 0, 64'h4000, 64'd1, 64'h0, 5'd1);
    flush = 1; #1;
    chk("fexc", ev, 0);
    @(negedge clk);
    flush = 0;
    chk("fexc_ready", ready, 1);
    go_req(1, 2'd2, 0, 64'h4000, 64'd0, 64'h0, 5'd1);
    mreq_ready = 1;
    @(negedge clk);
    mreq_ready = 0; flush = 1; #1;
    chk("fdone", sd, 0);
    @(negedge clk);
    flush = 0;
    chk("fdone_ready", ready, 1);
    // flush in IDLE blocks acceptance
    flush = 1; req_valid = 1; size = 2'd2; base = 64'h0; offset = 64'h0;
    @(negedge clk);
    flush = 0; req_valid = 0;
    chk("fidle", {busy, mv}, 2'b00);
    // reset while waiting for a load response
    go_req(0, 2'd2, 0, 64'h4000, 64'd0, 64'h0, 5'd2);
    mreq_ready = 1;
    @(negedge clk);
    mreq_ready = 0; rst_n = 0;
    @(negedge clk);
    chk_reset("rst_wait");
    rst_n = 1;
    @(negedge clk);
    for (int n = 0; n < 150; n++) begin
      logic [63:0] b, o;
      logic [1:0] sz;
      int nb;
      x64 = $urandom_range(0, 1); #1;
      sz = $urandom;
      nb = 1 << sz;
      b = {$urandom, $urandom};
      o = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) o = o - ((b + o) & 64'(nb - 1));
      run($urandom, sz, $urandom, b, o, {$urandom, $urandom}, 5'($urandom),
          $urandom_range(0, 3), $urandom_range(1, 3), {$urandom, $urandom});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
